// File: rtl/rpc_cfg_seq_pkg.sv
// Shared types and constants for the RPC DRAM configuration sequencer:
// table entry format, regbus request/response structs, FSM state encoding
// and a default power-up table for the controller's PHY/timing registers.
package rpc_cfg_seq_pkg;

  localparam int unsigned CfgAddrWidth = 48;
  localparam int unsigned CfgDataWidth = 32;
  localparam int unsigned CfgStrbWidth = CfgDataWidth / 8;
  localparam int unsigned WaitCntWidth = 16;

  // Table opcodes; the encoding is part of the table format.
  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_POLL  = 2'd1,
    OP_WAIT  = 2'd2,
    OP_END   = 2'd3
  } cfg_op_e;

  typedef struct packed {
    cfg_op_e                 op;
    logic [CfgAddrWidth-1:0] addr;
    logic [CfgDataWidth-1:0] data;
    logic [CfgDataWidth-1:0] mask;
  } cfg_entry_t;

  typedef struct packed {
    logic [CfgAddrWidth-1:0] addr;
    logic                    write;
    logic [CfgDataWidth-1:0] wdata;
    logic [CfgStrbWidth-1:0] wstrb;
    logic                    valid;
  } rpc_reg_req_t;

  typedef struct packed {
    logic [CfgDataWidth-1:0] rdata;
    logic                    error;
    logic                    ready;
  } rpc_reg_rsp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_REQ,
    ST_WAIT_CNT,
    ST_DONE,
    ST_ERROR
  } seq_state_e;

  // Index width for a table of n entries; a one-entry table still needs a bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Power-up table: program PHY delays and timings, let the PHY settle,
  // kick the init engine and wait for its ready bit.
  localparam int unsigned DefaultInitEntries = 8;
  localparam cfg_entry_t DefaultInitTable [DefaultInitEntries] = '{
    '{op: OP_WRITE, addr: 48'h0000_0000_0010, data: 32'h0000_0003, mask: 32'hFFFF_FFFF}, // DQS delay
    '{op: OP_WRITE, addr: 48'h0000_0000_0014, data: 32'h0000_0002, mask: 32'hFFFF_FFFF}, // CA delay
    '{op: OP_WRITE, addr: 48'h0000_0000_0020, data: 32'h0006_0006, mask: 32'hFFFF_FFFF}, // tRCD / tRP
    '{op: OP_WRITE, addr: 48'h0000_0000_0024, data: 32'h0000_0048, mask: 32'hFFFF_FFFF}, // tRFC
    '{op: OP_WAIT,  addr: 48'h0000_0000_0000, data: 32'h0000_00C8, mask: 32'h0000_0000}, // PHY settle
    '{op: OP_WRITE, addr: 48'h0000_0000_0000, data: 32'h0000_0001, mask: 32'hFFFF_FFFF}, // start init
    '{op: OP_POLL,  addr: 48'h0000_0000_0004, data: 32'h0000_0001, mask: 32'h0000_0001}, // init ready
    '{op: OP_END,   addr: 48'h0000_0000_0000, data: 32'h0000_0000, mask: 32'h0000_0000}
  };

endpackage

// File: rtl/rpc_cfg_seq_poll_cmp.sv
// Masked status compare and poll-attempt bookkeeping for POLL entries.
// Purely combinational; the attempt counter itself lives in the sequencer.
module rpc_cfg_seq_poll_cmp #(
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned PollTimeout = 1024,
  parameter int unsigned CntW        = $clog2(PollTimeout + 1)
) (
  input  logic [DataWidth-1:0] rdata_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic [DataWidth-1:0] mask_i,
  input  logic [CntW-1:0]      poll_cnt_i,
  output logic                 match_o,
  output logic                 last_o,
  output logic [CntW-1:0]      poll_cnt_next_o
);

  // Only the masked bits take part in the comparison.
  assign match_o = ((rdata_i & mask_i) == (data_i & mask_i));

  // The read in flight is the final permitted attempt.
  assign last_o = (poll_cnt_i == CntW'(PollTimeout - 1));

  // Never wraps: the sequencer only increments when last_o is low.
  assign poll_cnt_next_o = poll_cnt_i + 1'b1;

endmodule

// File: rtl/rpc_cfg_sequencer.sv
// Post-reset configuration sequencer for the RPC DRAM controller. Walks a
// table of WRITE / POLL / WAIT / END entries and drives the controller's
// regbus slave port, then reports done or error (with the failing index).
module rpc_cfg_sequencer
  import rpc_cfg_seq_pkg::*;
#(
  parameter int unsigned NumEntries   = 8,
  parameter int unsigned RegAddrWidth = CfgAddrWidth,
  parameter int unsigned RegDataWidth = CfgDataWidth,
  parameter int unsigned PollTimeout  = 1024,
  parameter type         reg_req_t    = rpc_reg_req_t,
  parameter type         reg_rsp_t    = rpc_reg_rsp_t,
  localparam int unsigned IdxW        = idx_width(NumEntries)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  cfg_entry_t      cfg_table_i [NumEntries],
  output reg_req_t        reg_req_o,
  input  reg_rsp_t        reg_rsp_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            error_o,
  output logic [IdxW-1:0] err_idx_o
);

  localparam int unsigned CntW    = $clog2(PollTimeout + 1);
  localparam int unsigned StrbW   = RegDataWidth / 8;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumEntries - 1);

  seq_state_e              state_q, state_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [CntW-1:0]         poll_cnt_q, poll_cnt_d;
  logic [WaitCntWidth-1:0] wait_cnt_q, wait_cnt_d;
  reg_req_t                req_q, req_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic [IdxW-1:0]         err_idx_q, err_idx_d;

  cfg_entry_t              entry;
  logic                    poll_match;
  logic                    poll_last;
  logic [CntW-1:0]         poll_cnt_inc;
  logic                    advance;
  logic                    finish;
  logic                    fail;

  // Current table entry; the table is held static while busy.
  assign entry = cfg_table_i[idx_q];

  rpc_cfg_seq_poll_cmp #(
    .DataWidth   (RegDataWidth),
    .PollTimeout (PollTimeout),
    .CntW        (CntW)
  ) u_poll_cmp (
    .rdata_i         (reg_rsp_i.rdata),
    .data_i          (entry.data),
    .mask_i          (entry.mask),
    .poll_cnt_i      (poll_cnt_q),
    .match_o         (poll_match),
    .last_o          (poll_last),
    .poll_cnt_next_o (poll_cnt_inc)
  );

  // Next-state, request and status decode for the table walker.
  always_comb begin
    // NOTE: every _d starts from its held value so no branch of the case can leave it unassigned and infer a latch.
    state_d    = state_q;
    idx_d      = idx_q;
    poll_cnt_d = poll_cnt_q;
    wait_cnt_d = wait_cnt_q;
    req_d      = req_q;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;
    err_idx_d  = err_idx_q;
    advance    = 1'b0;
    finish     = 1'b0;
    fail       = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        // Start is only honoured when no sequence is running.
        if (start_i) begin
          state_d    = ST_FETCH;
          idx_d      = '0;
          poll_cnt_d = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          error_d    = 1'b0;
          err_idx_d  = '0;
        end
      end

      ST_FETCH: begin
        unique case (entry.op)
          OP_WRITE, OP_POLL: begin
            // Request fields are registered here and held until the handshake.
            req_d       = '0;
            req_d.addr  = RegAddrWidth'(entry.addr);
            req_d.write = (entry.op == OP_WRITE);
            if (entry.op == OP_WRITE) begin
              req_d.wdata = RegDataWidth'(entry.data);
              req_d.wstrb = {StrbW{1'b1}};
            end
            req_d.valid = 1'b1;
            state_d     = ST_REQ;
          end
          OP_WAIT: begin
            if (entry.data[WaitCntWidth-1:0] == '0) begin
              advance = 1'b1;
            end else begin
              wait_cnt_d = entry.data[WaitCntWidth-1:0];
              state_d    = ST_WAIT_CNT;
            end
          end
          OP_END: begin
            finish = 1'b1;
          end
        endcase
      end

      ST_REQ: begin
        // rdata and error are only meaningful in the ready cycle.
        if (req_q.valid && reg_rsp_i.ready) begin
          req_d = '0;
          if (reg_rsp_i.error) begin
            fail = 1'b1;
          end else if (req_q.write || poll_match) begin
            advance = 1'b1;
          end else if (poll_last) begin
            fail = 1'b1;
          end else begin
            // Re-read the same entry after the mandatory FETCH gap.
            poll_cnt_d = poll_cnt_inc;
            state_d    = ST_FETCH;
          end
        end
      end

      ST_WAIT_CNT: begin
        if (wait_cnt_q == WaitCntWidth'(1)) begin
          advance = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Running off the end of the table behaves like an END entry.
    if (advance) begin
      poll_cnt_d = '0;
      if (idx_q == LastIdx) begin
        finish = 1'b1;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = ST_FETCH;
      end
    end

    if (finish) begin
      state_d = ST_DONE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end

    if (fail) begin
      state_d   = ST_ERROR;
      busy_d    = 1'b0;
      error_d   = 1'b1;
      err_idx_d = idx_q;
    end
  end

  // State, request and status registers; reset abandons any request in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      poll_cnt_q <= '0;
      wait_cnt_q <= '0;
      req_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_idx_q  <= '0;
    end else begin
      // NOTE: non-blocking so every flop captures the pre-edge _d values simultaneously.
      state_q    <= state_d;
      idx_q      <= idx_d;
      poll_cnt_q <= poll_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      req_q      <= req_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_idx_q  <= err_idx_d;
    end
  end

  assign reg_req_o = req_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign error_o   = error_q;
  assign err_idx_o = err_idx_q;

endmodule

// File: tb/tb_rpc_cfg_sequencer.sv
// Self-checking bench for rpc_cfg_sequencer: a regbus slave model with
// configurable latency, read data and error injection, a scoreboard of
// expected transactions, a table of POLL compare vectors and hand-written
// sequences for writes, timeouts, errors, waits, exhaustion and reset.
module tb_rpc_cfg_sequencer;
  import rpc_cfg_seq_pkg::*;

  localparam int unsigned NumEntries  = 8;
  localparam int unsigned PollTimeout = 4;
  localparam int unsigned IdxW        = 3;

  typedef struct {
    logic        write;
    logic [47:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    logic [31:0] data;
    logic [31:0] mask;
    logic [31:0] rdata;
    logic        exp_match;
  } pvec_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  cfg_entry_t      tbl [NumEntries];
  rpc_reg_req_t    req;
  rpc_reg_rsp_t    rsp = '0;
  logic            busy, done, error;
  logic [IdxW-1:0] err_idx;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Slave model state.
  int          lat = 2;
  logic [31:0] rd_q[$];
  logic [31:0] rd_default = '0;
  int          err_at = -1;
  int          txn_cnt = 0;
  int          wait_n = 0;
  int          last_ready_cyc = 0;
  int          first_rise_cyc = -1;
  logic        prev_valid = 1'b0;
  logic        cap_write;
  logic [47:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_wstrb;
  txn_t        exp_q[$];

  rpc_cfg_sequencer #(
    .NumEntries   (NumEntries),
    .RegAddrWidth (48),
    .RegDataWidth (32),
    .PollTimeout  (PollTimeout)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .cfg_table_i (tbl),
    .reg_req_o   (req),
    .reg_rsp_i   (rsp),
    .busy_o      (busy),
    .done_o      (done),
    .error_o     (error),
    .err_idx_o   (err_idx)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic cfg_entry_t ent(input cfg_op_e op, input logic [47:0] a,
                                     input logic [31:0] d, input logic [31:0] m);
    cfg_entry_t e;
    e.op = op; e.addr = a; e.data = d; e.mask = m;
    return e;
  endfunction

  task automatic clear_table();
    for (int i = 0; i < NumEntries; i++) tbl[i] = ent(OP_END, '0, '0, '0);
  endtask

  task automatic push_txn(input logic wr, input logic [47:0] a, input logic [31:0] d);
    txn_t t;
    t.write = wr; t.addr = a; t.wdata = d;
    exp_q.push_back(t);
  endtask

  // Compare one completed handshake against the head of the scoreboard.
  task automatic sb_pop();
    txn_t t;
    check("req_expected", exp_q.size() > 0, 1'b1);
    if (exp_q.size() > 0) begin
      t = exp_q.pop_front();
      check("txn_write", cap_write, t.write);
      check("txn_addr", cap_addr, t.addr);
      if (t.write) begin
        check("txn_wdata", cap_wdata, t.wdata);
        check("txn_wstrb", cap_wstrb, 4'hF);
      end
    end
  endtask

  // Regbus slave: sampled and driven on the falling edge.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      rsp = '0;
      wait_n = 0;
      prev_valid = 1'b0;
    end else begin
      if (rsp.ready) begin
        check("valid_drop", req.valid, 1'b0);
        rsp = '0;
        wait_n = 0;
        sb_pop();
        txn_cnt++;
      end else if (req.valid) begin
        if (!prev_valid) begin
          cap_write = req.write; cap_addr = req.addr;
          cap_wdata = req.wdata; cap_wstrb = req.wstrb;
          if (first_rise_cyc < 0) first_rise_cyc = cyc;
        end else begin
          check("req_stable_addr", req.addr, cap_addr);
          check("req_stable_ctl", {req.write, req.wstrb, req.wdata},
                {cap_write, cap_wstrb, cap_wdata});
        end
        wait_n++;
        if (wait_n >= lat) begin
          rsp.ready = 1'b1;
          rsp.error = (txn_cnt == err_at);
          rsp.rdata = (rd_q.size() > 0) ? rd_q.pop_front() : rd_default;
          last_ready_cyc = cyc;
        end
      end
      prev_valid = req.valid;
    end
  end

  // Start high during cycle n; returns #1 into cycle n+1.
  task automatic pulse_start(output int n);
    @(negedge clk);
    start = 1'b1;
    n = cyc;
    first_rise_cyc = -1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_end(input int budget, output int end_cyc);
    end_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done || error) begin
        end_cyc = cyc;
        break;
      end
    end
    check("end_reached", done | error, 1'b1);
  endtask

  pvec_t vecs [6];

  initial begin
    int n, n2, e, base;

    vecs[0] = '{data: 32'h0000_0001, mask: 32'h0000_0001, rdata: 32'h0000_0003, exp_match: 1'b1};
    vecs[1] = '{data: 32'h0000_00A5, mask: 32'h0000_00F0, rdata: 32'h0000_00A0, exp_match: 1'b1};
    vecs[2] = '{data: 32'h0000_00A5, mask: 32'h0000_00F0, rdata: 32'h0000_0050, exp_match: 1'b0};
    vecs[3] = '{data: 32'hFFFF_0000, mask: 32'h0000_0000, rdata: 32'h0000_1234, exp_match: 1'b1};
    vecs[4] = '{data: 32'h8000_0000, mask: 32'h8000_0000, rdata: 32'h7FFF_FFFF, exp_match: 1'b0};
    vecs[5] = '{data: 32'h1234_5678, mask: 32'hFFFF_FFFF, rdata: 32'h1234_5678, exp_match: 1'b1};

    clear_table();

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_req_zero", |req, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_err_idx", err_idx, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_valid", req.valid, 1'b0);

    // Write-only sequence.
    lat = 2;
    tbl[0] = ent(OP_WRITE, 48'h0, 32'h1, '0);
    tbl[1] = ent(OP_WRITE, 48'h4, 32'h5, '0);
    push_txn(1'b1, 48'h0, 32'h1);
    push_txn(1'b1, 48'h4, 32'h5);
    base = txn_cnt;
    pulse_start(n);
    check("w_busy_n1", busy, 1'b1);
    check("w_valid_n1", req.valid, 1'b0);
    @(posedge clk);
    #1 check("w_valid_n2", req.valid, 1'b1);
    wait_end(200, e);
    check("w_done", done, 1'b1);
    check("w_error", error, 1'b0);
    check("w_busy_low", busy, 1'b0);
    check("w_done_after_ready", e - last_ready_cyc, 2);
    check("w_txn_count", txn_cnt - base, 2);
    check("w_sb_empty", exp_q.size(), 0);

    // Poll success after two mismatches.
    clear_table();
    tbl[0] = ent(OP_POLL, 48'h10, 32'h1, 32'h1);
    rd_q = '{32'h0, 32'h0, 32'h3};
    for (int i = 0; i < 3; i++) push_txn(1'b0, 48'h10, '0);
    base = txn_cnt;
    pulse_start(n);
    wait_end(200, e);
    check("p_done", done, 1'b1);
    check("p_error", error, 1'b0);
    check("p_reads", txn_cnt - base, 3);
    check("p_sb_empty", exp_q.size(), 0);

    // Poll timeout at entry 1.
    clear_table();
    rd_q.delete();
    rd_default = '0;
    tbl[0] = ent(OP_WRITE, 48'h20, 32'h7, '0);
    tbl[1] = ent(OP_POLL, 48'h24, 32'h5, 32'hFF);
    push_txn(1'b1, 48'h20, 32'h7);
    for (int i = 0; i < PollTimeout; i++) push_txn(1'b0, 48'h24, '0);
    base = txn_cnt;
    pulse_start(n);
    wait_end(300, e);
    check("t_error", error, 1'b1);
    check("t_done", done, 1'b0);
    check("t_err_idx", err_idx, 1);
    check("t_busy", busy, 1'b0);
    repeat (20) @(negedge clk);
    check("t_txn_count", txn_cnt - base, 1 + PollTimeout);
    check("t_sb_empty", exp_q.size(), 0);

    // Regbus error on entry 2.
    clear_table();
    for (int i = 0; i < 4; i++) tbl[i] = ent(OP_WRITE, 48'(32'h40 + 4 * i), 32'(32'hB0 + i), '0);
    for (int i = 0; i < 3; i++) push_txn(1'b1, 48'(32'h40 + 4 * i), 32'(32'hB0 + i));
    base = txn_cnt;
    err_at = base + 2;
    pulse_start(n);
    check("e_flags_cleared", error, 1'b0);
    wait_end(300, e);
    check("e_error", error, 1'b1);
    check("e_err_idx", err_idx, 2);
    check("e_done", done, 1'b0);
    repeat (20) @(negedge clk);
    check("e_txn_count", txn_cnt - base, 3);
    check("e_sb_empty", exp_q.size(), 0);
    err_at = -1;

    // WAIT 5 then writes with no END; rerun from a second start.
    tbl[0] = ent(OP_WAIT, '0, 32'd5, '0);
    for (int i = 1; i < NumEntries; i++) tbl[i] = ent(OP_WRITE, 48'(32'h100 + 4 * i), 32'(32'hA0 + i), '0);
    for (int r = 0; r < 2; r++) begin
      for (int i = 1; i < NumEntries; i++) push_txn(1'b1, 48'(32'h100 + 4 * i), 32'(32'hA0 + i));
      base = txn_cnt;
      pulse_start(n2);
      check("x_done_cleared", done, 1'b0);
      check("x_error_cleared", error, 1'b0);
      check("x_busy", busy, 1'b1);
      wait_end(400, e);
      check("x_first_valid", first_rise_cyc - n2, 8);
      check("x_done", done, 1'b1);
      check("x_txn_count", txn_cnt - base, NumEntries - 1);
      check("x_sb_empty", exp_q.size(), 0);
    end

    // WAIT 0 advances straight to the next entry.
    clear_table();
    tbl[0] = ent(OP_WAIT, '0, 32'hFFFF_0000, '0);
    tbl[1] = ent(OP_WRITE, 48'h200, 32'h55, '0);
    push_txn(1'b1, 48'h200, 32'h55);
    pulse_start(n);
    wait_end(100, e);
    check("z_first_valid", first_rise_cyc - n, 3);
    check("z_done", done, 1'b1);

    // Table-driven masked compare vectors.
    lat = 1;
    foreach (vecs[v]) begin
      clear_table();
      tbl[0] = ent(OP_POLL, 48'h40, vecs[v].data, vecs[v].mask);
      rd_default = vecs[v].rdata;
      for (int i = 0; i < (vecs[v].exp_match ? 1 : PollTimeout); i++) push_txn(1'b0, 48'h40, '0);
      base = txn_cnt;
      pulse_start(n);
      wait_end(200, e);
      check("v_done", done, vecs[v].exp_match);
      check("v_error", error, !vecs[v].exp_match);
      check("v_reads", txn_cnt - base, vecs[v].exp_match ? 1 : PollTimeout);
      check("v_sb_empty", exp_q.size(), 0);
    end

    // Reset while a poll request is outstanding.
    lat = 6;
    rd_default = '0;
    clear_table();
    tbl[0] = ent(OP_POLL, 48'h30, 32'h1, 32'h1);
    push_txn(1'b0, 48'h30, '0);
    base = txn_cnt;
    pulse_start(n);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (req.valid) break;
    end
    check("r_valid_before", req.valid, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("r_req_zero", |req, 1'b0);
    check("r_busy", busy, 1'b0);
    check("r_done", done, 1'b0);
    check("r_error", error, 1'b0);
    check("r_err_idx", err_idx, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    first_rise_cyc = -1;
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("r_no_req_after", first_rise_cyc < 0, 1'b1);
    check("r_txn_count", txn_cnt - base, 0);
    check("r_idle", busy, 1'b0);
    rd_default = 32'h1;
    push_txn(1'b0, 48'h30, '0);
    pulse_start(n);
    wait_end(100, e);
    check("r_restart_done", done, 1'b1);
    check("r_sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
